cim_inst_sequencer: RTL and testbench
=====================================

Name: cim_inst_sequencer

Overview:
- Single-issue sequencer between the instruction source and the compute-in-memory array.
- Accepts 32-bit CIM instructions over a valid/ready handshake.
- Decodes the fields op[31:24], s1[23:16], s2[15:8] and d1[7:0].
- Drives the array through a fixed DECODE -> EXEC -> WB sequence, flags illegal opcodes, and supports a HALT/resume mechanism.

Parameters:
- OP_W, 8, opcode field width.
- ADDR_W, 8, row address width; the array has 2**ADDR_W = 256 rows.
- EXEC_CYCLES, 2, array compute cycles per instruction. Legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- inst_valid  in  1  instruction available.
- inst_ready  out  1  sequencer can accept an instruction.
- inst_data  in  32  instruction word {op,s1,s2,d1}.
- resume  in  1  one-cycle pulse; leaves HALTED.
- array_stall  in  1  array back-pressure; freezes EXEC/WB.
- array_en  out  1  compute enable.
- array_op  out  3  decoded op code: 1=AND 2=OR 3=XOR 4=NOT 5=COPY.
- array_src1  out  ADDR_W  source row 1.
- array_src2  out  ADDR_W  source row 2.
- array_dst  out  ADDR_W  destination row.
- array_wr  out  1  write-back strobe.
- retire  out  1  one-cycle pulse per completed instruction, including NOP.
- busy  out  1  high in any state other than IDLE.
- halted  out  1  high in HALTED.
- illegal_err  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all outputs 0 except inst_ready=1; instruction register cleared; EXEC counter cleared; illegal_err cleared. Reset mid-instruction aborts the instruction with no array_wr and no retire.
- IDLE:
  - inst_ready=1.
  - On inst_valid&inst_ready, latch inst_data and go to DECODE.
  - inst_ready is 0 in every other state, so the sequencer never holds two instructions.
- DECODE (1 cycle), by opcode:
  - 0x00 NOP: retire=1, go to IDLE.
  - 0x01 AND, 0x02 OR, 0x03 XOR: array_op set to 1, 2, 3; go to EXEC.
  - 0x04 NOT, 0x05 COPY: array_op set to 4, 5; array_src2 forced to 0 (s2 ignored); go to EXEC.
  - 0xFF HALT: retire=1, go to HALTED.
  - Any other value: illegal_err<=1 (sticky until reset), no retire, go to IDLE.
- EXEC:
  - array_en=1; array_src1/src2/dst/op held stable.
  - The counter increments each cycle in which array_stall=0. When it reaches EXEC_CYCLES-1 with no stall, go to WB.
  - array_stall=1 holds both state and counter; array_en stays 1.
- WB:
  - array_wr=1 with array_dst=d1.
  - If array_stall=0, retire=1 that same cycle and go to IDLE. If stalled, stay in WB with array_wr held.
- Address outputs are 0 in IDLE and HALTED, and valid from DECODE through WB.
- HALTED:
  - halted=1, busy=1, inst_ready=0.
  - resume=1 returns to IDLE. resume in any other state is ignored.
- Timing with no stall: handshake in cycle T, DECODE in T+1, EXEC in T+2..T+1+EXEC_CYCLES, WB/retire in T+2+EXEC_CYCLES, inst_ready high again in T+3+EXEC_CYCLES.
- d1 may equal s1 or s2. There is no hazard logic; ordering is guaranteed by single issue.

Optional Feature:
- Macro CIM_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output ports retired_cnt[31:0], stall_cnt[31:0] and illegal_cnt[15:0]. All reset to 0.
  - retired_cnt increments on retire.
  - stall_cnt increments each cycle array_stall=1 while in EXEC or WB.
  - illegal_cnt increments on each illegal opcode and saturates at 0xFFFF.
  - All counters wrap except illegal_cnt.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- AND: inst_data=0x01_10_20_30, EXEC_CYCLES=2, no stall -> array_en high in cycles T+2..T+3 with src1=0x10, src2=0x20, array_op=1; array_wr and retire in T+4 with dst=0x30; inst_ready high in T+5.
- NOT: inst 0x04_05_AA_06 with array_stall=1 for 3 cycles in the first EXEC cycle -> array_src2=0; WB occurs 3 cycles later than the no-stall case; exactly one array_wr pulse at retire.
- NOP then illegal: inst 0x00_xx, then 0x7E_xx -> NOP gives retire 1 cycle after accept with no array_en; the 0x7E gives illegal_err=1 that stays high through a following legal XOR; the XOR completes normally.
- HALT: inst 0xFF_00_00_00 while inst_valid is held high -> halted=1, inst_ready=0 for 10 cycles; resume pulse -> IDLE; next instruction accepted the following cycle.
- Reset: rst_n low during EXEC of a COPY (0x05_01_00_02) -> no array_wr and no retire; all outputs at reset values; illegal_err=0.
- Back-to-back with CIM_SEQ_PERF_CNT_EN defined: 4 ORs with no stalls -> retired_cnt=4, stall_cnt=0; one stalled WB for 2 cycles -> stall_cnt=2.

Source files
------------

// File: rtl/cim_inst_sequencer.sv
// Single-issue CIM instruction sequencer: accept -> DECODE -> EXEC -> WB, with HALT/resume.
// Optional performance counters are enabled by defining CIM_SEQ_PERF_CNT_EN.
module cim_inst_sequencer #(
    parameter int unsigned OP_W        = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [31:0]       inst_data,
    input  logic              resume,
    input  logic              array_stall,
    output logic              array_en,
    output logic [2:0]        array_op,
    output logic [ADDR_W-1:0] array_src1,
    output logic [ADDR_W-1:0] array_src2,
    output logic [ADDR_W-1:0] array_dst,
    output logic              array_wr,
    output logic              retire,
    output logic              busy,
    output logic              halted,
    output logic              illegal_err
`ifdef CIM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       illegal_cnt
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(8'h00);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(8'h01);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(8'h02);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(8'h03);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(8'h04);
    localparam logic [OP_W-1:0] OP_COPY = OP_W'(8'h05);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(8'hFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_inst;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_illegal;
    logic             w_illegal_set;
    logic [OP_W-1:0]  w_op;
    logic [2:0]       w_aop;
    logic             w_one_src;
    logic             w_active;

    assign w_op = r_inst[31 -: OP_W];

    // Opcode to array operation; w_aop == 0 means not an array instruction
    always_comb begin
        w_aop     = 3'd0;
        w_one_src = 1'b0;
        case (w_op)
            OP_AND:  w_aop = 3'd1;
            OP_OR:   w_aop = 3'd2;
            OP_XOR:  w_aop = 3'd3;
            OP_NOT:  begin w_aop = 3'd4; w_one_src = 1'b1; end
            OP_COPY: begin w_aop = 3'd5; w_one_src = 1'b1; end
            default: w_aop = 3'd0;
        endcase
    end

    // Next-state, counter and output decode
    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt;
        w_illegal_set = 1'b0;
        inst_ready    = 1'b0;
        busy          = 1'b1;
        halted        = 1'b0;
        array_en      = 1'b0;
        array_wr      = 1'b0;
        retire        = 1'b0;
        w_active      = 1'b0;
        case (r_state)
            S_IDLE: begin
                inst_ready = 1'b1;
                busy       = 1'b0;
                if (inst_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_active   = 1'b1;
                w_cnt_next = '0;
                if (w_op == OP_NOP) begin
                    retire = 1'b1;
                    w_next = S_IDLE;
                end else if (w_op == OP_HALT) begin
                    retire = 1'b1;
                    w_next = S_HALTED;
                end else if (w_aop != 3'd0) begin
                    w_next = S_EXEC;
                end else begin
                    w_illegal_set = 1'b1;
                    w_next        = S_IDLE;
                end
            end
            S_EXEC: begin
                w_active = 1'b1;
                array_en = 1'b1;
                if (!array_stall) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_next = '0;
                        w_next     = S_WB;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_WB: begin
                w_active = 1'b1;
                array_wr = 1'b1;
                if (!array_stall) begin
                    retire = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
                if (resume) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Addresses and op are only driven while an instruction is in flight
    always_comb begin
        array_op   = 3'd0;
        array_src1 = '0;
        array_src2 = '0;
        array_dst  = '0;
        if (w_active) begin
            array_op   = w_aop;
            array_src1 = ADDR_W'(r_inst[23:16]);
            array_src2 = w_one_src ? '0 : ADDR_W'(r_inst[15:8]);
            array_dst  = ADDR_W'(r_inst[7:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_inst    <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && inst_valid) r_inst <= inst_data;
            if (w_illegal_set) r_illegal <= 1'b1;
        end
    end

    assign illegal_err = r_illegal;

`ifdef CIM_SEQ_PERF_CNT_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_stall_cnt;
    logic [15:0] r_illegal_cnt;

    // Retire and stall counters wrap; illegal counter saturates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired_cnt <= '0;
            r_stall_cnt   <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (retire) r_retired_cnt <= r_retired_cnt + 32'd1;
            if (array_stall && (r_state == S_EXEC || r_state == S_WB))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_illegal_set && r_illegal_cnt != 16'hFFFF)
                r_illegal_cnt <= r_illegal_cnt + 16'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign stall_cnt   = r_stall_cnt;
    assign illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_cim_inst_sequencer.sv
// Directed self-checking bench for cim_inst_sequencer (EXEC_CYCLES = 2).
// Status vector st = {inst_ready, busy, halted, array_en, array_wr, retire, array_op[2:0], illegal_err}.
module tb_cim_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic        resume;
    logic        array_stall;
    logic        array_en;
    logic [2:0]  array_op;
    logic [7:0]  array_src1;
    logic [7:0]  array_src2;
    logic [7:0]  array_dst;
    logic        array_wr;
    logic        retire;
    logic        busy;
    logic        halted;
    logic        illegal_err;
`ifdef CIM_SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
    logic [15:0] illegal_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [9:0]  st;
    logic [23:0] addr;
    assign st   = {inst_ready, busy, halted, array_en, array_wr, retire, array_op, illegal_err};
    assign addr = {array_src1, array_src2, array_dst};

    always #5 clk = ~clk;

    cim_inst_sequencer #(.OP_W(8), .ADDR_W(8), .EXEC_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .resume      (resume),
        .array_stall (array_stall),
        .array_en    (array_en),
        .array_op    (array_op),
        .array_src1  (array_src1),
        .array_src2  (array_src2),
        .array_dst   (array_dst),
        .array_wr    (array_wr),
        .retire      (retire),
        .busy        (busy),
        .halted      (halted),
        .illegal_err (illegal_err)
`ifdef CIM_SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    task automatic drv(input logic v, input logic [31:0] d, input logic s, input logic r);
        inst_valid  = v;
        inst_data   = d;
        array_stall = s;
        resume      = r;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drv(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (st !== 10'b1000000000) begin
            errors++;
            $display("FAIL reset_status got %b exp %b", st, 10'b1000000000);
        end
        checks++;
        if (addr !== 24'h0) begin
            errors++;
            $display("FAIL reset_addr got %h exp %h", addr, 24'h0);
        end
`ifdef CIM_SEQ_PERF_CNT_EN
        checks++;
        if (retired_cnt !== 32'd0 || stall_cnt !== 32'd0 || illegal_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf got %0d/%0d/%0d exp 0/0/0", retired_cnt, stall_cnt, illegal_cnt);
        end
`endif
        step();
    endtask

    task automatic test_and();
        logic [9:0] ex [6];
        ex = '{10'b1000000000, 10'b0100000010, 10'b0101000010,
               10'b0101000010, 10'b0100110010, 10'b1000000000};
        for (int i = 0; i < 6; i++) begin
            drv(i == 0, 32'h01102030, 1'b0, 1'b0);
            checks++;
            if (st !== ex[i]) begin
                errors++;
                $display("FAIL and_status cyc %0d got %b exp %b", i, st, ex[i]);
            end
            if (i == 2 || i == 4) begin
                checks++;
                if (addr !== 24'h102030) begin
                    errors++;
                    $display("FAIL and_addr cyc %0d got %h exp %h", i, addr, 24'h102030);
                end
            end
            if (i == 5) begin
                checks++;
                if (addr !== 24'h0) begin
                    errors++;
                    $display("FAIL and_addr_idle got %h exp %h", addr, 24'h0);
                end
            end
            step();
        end
    endtask

    task automatic test_not_stall();
        logic [9:0] ex;
        int wrs = 0;
        for (int i = 0; i < 9; i++) begin
            drv(i == 0, 32'h0405AA06, (i >= 2 && i <= 4), 1'b0);
            if (i == 0 || i == 8)      ex = 10'b1000000000;
            else if (i == 1)           ex = 10'b0100001000;
            else if (i <= 6)           ex = 10'b0101001000;
            else                       ex = 10'b0100111000;
            checks++;
            if (st !== ex) begin
                errors++;
                $display("FAIL not_status cyc %0d got %b exp %b", i, st, ex);
            end
            if (i == 1 || i == 3 || i == 7) begin
                checks++;
                if (addr !== 24'h050006) begin
                    errors++;
                    $display("FAIL not_addr cyc %0d got %h exp %h", i, addr, 24'h050006);
                end
            end
            if (array_wr) wrs++;
            step();
        end
        checks++;
        if (wrs != 1) begin
            errors++;
            $display("FAIL not_wr_pulses got %0d exp 1", wrs);
        end
    endtask

    task automatic test_nop_illegal();
        logic [9:0]  ex [10];
        logic [31:0] d;
        ex = '{10'b1000000000, 10'b0100010000, 10'b1000000000, 10'b0100000000,
               10'b1000000001, 10'b0100000111, 10'b0101000111, 10'b0101000111,
               10'b0100110111, 10'b1000000001};
        for (int i = 0; i < 10; i++) begin
            d = (i == 0) ? 32'h00123456 : (i == 2) ? 32'h7E000000 : 32'h03112233;
            drv(i == 0 || i == 2 || i == 4, d, 1'b0, 1'b0);
            checks++;
            if (st !== ex[i]) begin
                errors++;
                $display("FAIL nop_illegal_status cyc %0d got %b exp %b", i, st, ex[i]);
            end
            if (i == 6 || i == 8) begin
                checks++;
                if (addr !== 24'h112233) begin
                    errors++;
                    $display("FAIL xor_addr cyc %0d got %h exp %h", i, addr, 24'h112233);
                end
            end
            step();
        end
    endtask

    task automatic test_halt();
        logic [9:0] ex;
        // resume outside HALTED has no effect
        drv(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        drv(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (st !== 10'b1000000001) begin
            errors++;
            $display("FAIL resume_in_idle got %b exp %b", st, 10'b1000000001);
        end
        for (int i = 0; i < 19; i++) begin
            drv(i < 14, (i == 0) ? 32'hFF000000 : 32'h01AABBCC, 1'b0, i == 12);
            if (i == 0 || i == 13 || i == 18) ex = 10'b1000000001;
            else if (i == 1)                  ex = 10'b0100010001;
            else if (i <= 12)                 ex = 10'b0110000001;
            else if (i == 14)                 ex = 10'b0100000011;
            else if (i <= 16)                 ex = 10'b0101000011;
            else                              ex = 10'b0100110011;
            checks++;
            if (st !== ex) begin
                errors++;
                $display("FAIL halt_status cyc %0d got %b exp %b", i, st, ex);
            end
            if (i == 5 || i == 16) begin
                checks++;
                if (addr !== ((i == 5) ? 24'h0 : 24'hAABBCC)) begin
                    errors++;
                    $display("FAIL halt_addr cyc %0d got %h", i, addr);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] ex;
        int events = 0;
        for (int i = 0; i < 7; i++) begin
            rst_n = (i != 2);
            drv(i == 0, 32'h05010002, 1'b0, 1'b0);
            if (i == 0)      ex = 10'b1000000001;
            else if (i == 1) ex = 10'b0100001011;
            else if (i == 2) ex = 10'b0101001011;
            else             ex = 10'b1000000000;
            checks++;
            if (st !== ex) begin
                errors++;
                $display("FAIL reset_mid_status cyc %0d got %b exp %b", i, st, ex);
            end
            if (array_wr || retire) events++;
            if (i == 3) begin
                checks++;
                if (addr !== 24'h0) begin
                    errors++;
                    $display("FAIL reset_mid_addr got %h exp %h", addr, 24'h0);
                end
            end
            step();
        end
        checks++;
        if (events != 0) begin
            errors++;
            $display("FAIL reset_mid_wr_retire got %0d exp 0", events);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ret;
        rst_n = 1'b0;
        drv(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drv(i < 16, 32'h02010203, 1'b0, 1'b0);
            exp_ret = (i % 5) == 4;
            checks++;
            if (retire !== exp_ret || inst_ready !== ((i % 5) == 0)) begin
                errors++;
                $display("FAIL b2b_retire cyc %0d got ret %b rdy %b exp ret %b rdy %b",
                         i, retire, inst_ready, exp_ret, (i % 5) == 0);
            end
            step();
        end
`ifdef CIM_SEQ_PERF_CNT_EN
        checks++;
        if (retired_cnt !== 32'd4 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_b2b got ret %0d stall %0d exp 4 0", retired_cnt, stall_cnt);
        end
`endif
        // WB stalled for two cycles: retire slips from cycle 4 to cycle 6
        for (int i = 0; i < 8; i++) begin
            drv(i == 0, 32'h02040506, (i == 4 || i == 5), 1'b0);
            checks++;
            if (retire !== (i == 6) || array_wr !== (i >= 4 && i <= 6)) begin
                errors++;
                $display("FAIL wb_stall cyc %0d got ret %b wr %b", i, retire, array_wr);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drv(i == 0, 32'h80000000, 1'b0, 1'b0);
            step();
        end
        checks++;
        if (illegal_err !== 1'b1) begin
            errors++;
            $display("FAIL b2b_illegal got %b exp 1", illegal_err);
        end
`ifdef CIM_SEQ_PERF_CNT_EN
        checks++;
        if (retired_cnt !== 32'd5 || stall_cnt !== 32'd2 || illegal_cnt !== 16'd1) begin
            errors++;
            $display("FAIL perf_stall got ret %0d stall %0d ill %0d exp 5 2 1",
                     retired_cnt, stall_cnt, illegal_cnt);
        end
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        inst_valid  = 1'b0;
        inst_data   = 32'h0;
        resume      = 1'b0;
        array_stall = 1'b0;
        test_reset();
        test_and();
        test_not_stall();
        test_nop_illegal();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
